// File: rtl/pool_map_streamer_pkg.sv
// Shared definitions for the pooled-map streamer and the maxpool scheduler.
// Holds the FSM encoding and the two supported map geometries.
package pool_map_streamer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam int unsigned DIM_L0 = 12;
    localparam int unsigned DIM_L1 = 4;
    localparam int unsigned PIX_L0 = DIM_L0 * DIM_L0;
    localparam int unsigned PIX_L1 = DIM_L1 * DIM_L1;

    function automatic int unsigned map_pixels(input logic m);
        return m ? PIX_L1 : PIX_L0;
    endfunction

endpackage

// File: rtl/pool_map_streamer_if.sv
// Picture-memory read port and pixel output stream of the streamer.
// master = streamer side, slave = memory/consumer side.
interface pool_map_streamer_if #(
    parameter int ADDR_BIT = 10,
    parameter int DATA_BIT = 8
);
    logic [ADDR_BIT-1:0] mem_addr;
    logic                mem_re;
    logic [DATA_BIT-1:0] mem_rdata;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_BIT-1:0] out_data;
    logic                out_last;

    modport master (
        output mem_addr, mem_re,
        input  mem_rdata,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_addr, mem_re,
        output mem_rdata,
        input  out_valid, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/pool_map_streamer_fifo2.sv
// Two-entry FIFO with occupancy count; head held until popped.
// Caller guarantees no push when full and no pop when empty.
module stream_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wp_q, rp_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= ~wp_q;
            end
            if (pop_i) rp_q <= ~rp_q;
            unique case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rp_q];
    assign valid_o = cnt_q != 2'd0;
    assign count_o = cnt_q;
endmodule

// File: rtl/pool_map_streamer.sv
// Streams one pooled feature map from picture memory in row-major order,
// with credit-limited reads so a 2-entry FIFO absorbs downstream stalls.
module pool_map_streamer
    import pool_map_streamer_pkg::*;
#(
    parameter int ADDR_BIT = 10,
    parameter int DATA_BIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    output logic                busy,
    output logic                done,
    pool_map_streamer_if.master bus
);
    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ADDR_BIT-1:0] cnt_q, cnt_d, last_idx;
    logic                inflight_q, last_pend_q;
    logic                re, pop, is_last, fvalid;
    logic [1:0]          fcount;
    logic [DATA_BIT:0]   fhead;

    assign last_idx = ADDR_BIT'(map_pixels(mode_q) - 1);
    assign is_last  = cnt_q == last_idx;
    assign pop      = fvalid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        re      = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d = S_STREAM;
                mode_d  = mode;
                cnt_d   = '0;
            end
            // Issue only while FIFO slots cover every outstanding read.
            S_STREAM: if ({1'b0, fcount} + {2'b0, inflight_q}
                          < 3'd2 + {2'b0, pop}) begin
                re    = 1'b1;
                cnt_d = cnt_q + ADDR_BIT'(1);
                if (is_last) state_d = S_DRAIN;
            end
            S_DRAIN: if (fcount == 2'd0 && !inflight_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            last_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            inflight_q  <= re;
            last_pend_q <= re && is_last;
        end
    end

    stream_fifo2 #(.W(DATA_BIT + 1)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .din_i   ({last_pend_q, bus.mem_rdata}),
        .pop_i   (pop),
        .dout_o  (fhead),
        .valid_o (fvalid),
        .count_o (fcount)
    );

    assign bus.mem_re    = re;
    assign bus.mem_addr  = re ? cnt_q : '0;
    assign bus.out_valid = fvalid;
    assign bus.out_data  = fhead[DATA_BIT-1:0];
    assign bus.out_last  = fvalid && fhead[DATA_BIT];
    assign busy          = state_q != S_IDLE;
    assign done          = state_q == S_DONE;
endmodule

// File: tb/tb_pool_map_streamer.sv
// Randomized bench for pool_map_streamer: a memory model feeds the DUT and
// delivered beats are compared against memory contents in address order.
module tb_pool_map_streamer;
    localparam int AB   = 10;
    localparam int DB   = 8;
    localparam int MAXC = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic busy, done;

    pool_map_streamer_if #(.ADDR_BIT(AB), .DATA_BIT(DB)) bus ();

    pool_map_streamer #(.ADDR_BIT(AB), .DATA_BIT(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DB-1:0] mem [1024];
    always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];

    int n_cmp = 0;
    int n_bad = 0;

    logic [DB-1:0] beat_d[$];
    bit            beat_l[$];
    int            beat_k[$];
    int            addrs[$];
    int re_cycles, first_valid_k, done_k, done_cnt;
    int unstable, over_occ, reads_hold;
    bit timed_out, idle_after;

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 1024; i++)
            mem[i] = rnd ? DB'($urandom) : DB'(i);
    endtask

    // Run one map; record everything observed, judge nothing.
    task automatic run(input bit md, input bit rnd, input int hold,
                       input bit disturb, input int abort_beat);
        bit pv = 0, pr = 0, pl = 0;
        logic [DB-1:0] pd = '0;
        int issued = 0;
        beat_d.delete(); beat_l.delete(); beat_k.delete(); addrs.delete();
        re_cycles = 0; first_valid_k = -1; done_k = -1; done_cnt = 0;
        unstable = 0; over_occ = 0; reads_hold = 0;
        timed_out = 1; idle_after = 0;
        @(negedge clk);
        start = 1'b1; mode = md; bus.out_ready = 1'b0;
        for (int k = 1; k <= MAXC; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (disturb && k == 5) begin start = 1'b1; mode = ~md; end
            if (disturb && k == 6) start = 1'b0;
            if (k <= hold) bus.out_ready = 1'b0;
            else bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (issued - int'(beat_d.size()) > 2) over_occ++;
            if (bus.mem_re) begin
                addrs.push_back(int'(bus.mem_addr));
                re_cycles++;
                issued++;
            end
            if (k <= hold) reads_hold = issued;
            if (pv && !pr && (!bus.out_valid || bus.out_data !== pd
                              || bus.out_last !== pl)) unstable++;
            if (bus.out_valid && first_valid_k < 0) first_valid_k = k;
            if (bus.out_valid && bus.out_ready) begin
                beat_d.push_back(bus.out_data);
                beat_l.push_back(bus.out_last);
                beat_k.push_back(k);
            end
            if (done) begin done_cnt++; done_k = k; end
            if (done_k >= 0 && k == done_k + 1) idle_after = !busy;
            pv = bus.out_valid; pr = bus.out_ready;
            pd = bus.out_data;  pl = bus.out_last;
            if ((abort_beat >= 0 && int'(beat_d.size()) == abort_beat)
                || (done_k >= 0 && k == done_k + 2)) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.mem_re, bus.mem_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_mem: got re=%b addr=%0d want 0/0",
                     bus.mem_re, bus.mem_addr);
        end
        n_cmp++;
        if ({bus.out_valid, bus.out_last, bus.out_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_out: got v=%b l=%b d=%0h want 0",
                     bus.out_valid, bus.out_last, bus.out_data);
        end
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_status: got busy=%b done=%b want 0/0",
                     busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_small_map();
        int lk;
        fill_mem(0);
        run(1'b1, 1'b0, 0, 1'b0, -1);
        n_cmp++;
        if (timed_out || beat_d.size() != 16) begin
            n_bad++;
            $display("FAIL small_count: got %0d beats (timeout=%b) want 16",
                     beat_d.size(), timed_out);
        end
        for (int i = 0; i < beat_d.size() && i < 16; i++) begin
            n_cmp++;
            if (beat_d[i] !== DB'(i) || beat_l[i] !== (i == 15)) begin
                n_bad++;
                $display("FAIL small_beat%0d: got %0h/%b want %0h/%b",
                         i, beat_d[i], beat_l[i], i, i == 15);
            end
        end
        lk = beat_k.size() > 0 ? beat_k[beat_k.size() - 1] : -100;
        n_cmp++;
        if (done_k - lk != 2 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL small_done: got gap %0d pulses %0d want 2/1",
                     done_k - lk, done_cnt);
        end
        n_cmp++;
        if (re_cycles != 16) begin
            n_bad++;
            $display("FAIL small_reads: got %0d want 16", re_cycles);
        end
        for (int i = 0; i < addrs.size() && i < 16; i++) begin
            n_cmp++;
            if (addrs[i] != i) begin
                n_bad++;
                $display("FAIL small_addr%0d: got %0d want %0d",
                         i, addrs[i], i);
            end
        end
        n_cmp++;
        if (!idle_after) begin
            n_bad++;
            $display("FAIL small_idle: got busy after done want idle");
        end
    endtask

    task automatic test_large_map();
        fill_mem(0);
        run(1'b0, 1'b0, 0, 1'b0, -1);
        n_cmp++;
        if (timed_out || beat_d.size() != 144) begin
            n_bad++;
            $display("FAIL large_count: got %0d beats want 144",
                     beat_d.size());
        end
        n_cmp++;
        if (first_valid_k != 3) begin
            n_bad++;
            $display("FAIL large_latency: got %0d want 3", first_valid_k);
        end
        for (int i = 0; i < beat_d.size() && i < 144; i++) begin
            n_cmp++;
            if (beat_d[i] !== DB'(i) || beat_l[i] !== (i == 143)
                || beat_k[i] != 3 + i) begin
                n_bad++;
                $display("FAIL large_beat%0d: got %0h/%b @%0d want %0h/%b @%0d",
                         i, beat_d[i], beat_l[i], beat_k[i],
                         i, i == 143, 3 + i);
            end
        end
    endtask

    task automatic test_random_ready();
        fill_mem(1);
        run(1'b0, 1'b1, 0, 1'b0, -1);
        n_cmp++;
        if (timed_out || beat_d.size() != 144) begin
            n_bad++;
            $display("FAIL rnd_count: got %0d beats want 144", beat_d.size());
        end
        for (int i = 0; i < beat_d.size() && i < 144; i++) begin
            n_cmp++;
            if (beat_d[i] !== mem[i] || beat_l[i] !== (i == 143)) begin
                n_bad++;
                $display("FAIL rnd_beat%0d: got %0h/%b want %0h/%b",
                         i, beat_d[i], beat_l[i], mem[i], i == 143);
            end
        end
        n_cmp++;
        if (unstable != 0) begin
            n_bad++;
            $display("FAIL rnd_stable: got %0d changes want 0", unstable);
        end
        n_cmp++;
        if (over_occ != 0) begin
            n_bad++;
            $display("FAIL rnd_occupancy: got %0d overruns want 0", over_occ);
        end
    endtask

    task automatic test_hold();
        fill_mem(1);
        run(1'b1, 1'b0, 10, 1'b0, -1);
        n_cmp++;
        if (reads_hold != 2) begin
            n_bad++;
            $display("FAIL hold_reads: got %0d want 2", reads_hold);
        end
        n_cmp++;
        if (addrs.size() < 2 || addrs[0] != 0 || addrs[1] != 1) begin
            n_bad++;
            $display("FAIL hold_addr: got %0d entries want 0,1 first",
                     addrs.size());
        end
        n_cmp++;
        if (timed_out || beat_d.size() != 16) begin
            n_bad++;
            $display("FAIL hold_count: got %0d beats want 16", beat_d.size());
        end
        for (int i = 0; i < beat_d.size() && i < 16; i++) begin
            n_cmp++;
            if (beat_d[i] !== mem[i]) begin
                n_bad++;
                $display("FAIL hold_beat%0d: got %0h want %0h",
                         i, beat_d[i], mem[i]);
            end
        end
    endtask

    task automatic test_disturb();
        for (int m = 0; m < 2; m++) begin
            int tot = (m == 1) ? 16 : 144;
            fill_mem(1);
            run(1'(m), 1'b0, 0, 1'b1, -1);
            n_cmp++;
            if (timed_out || beat_d.size() != tot || done_cnt != 1) begin
                n_bad++;
                $display("FAIL disturb_m%0d: got %0d beats %0d dones want %0d/1",
                         m, beat_d.size(), done_cnt, tot);
            end
            for (int i = 0; i < beat_d.size() && i < tot; i++) begin
                n_cmp++;
                if (beat_d[i] !== mem[i]) begin
                    n_bad++;
                    $display("FAIL disturb_m%0d_beat%0d: got %0h want %0h",
                             m, i, beat_d[i], mem[i]);
                end
            end
        end
    endtask

    task automatic test_abort();
        bit saw_done = 0;
        fill_mem(1);
        run(1'b0, 1'b0, 0, 1'b0, 50);
        n_cmp++;
        if (timed_out || beat_d.size() != 50) begin
            n_bad++;
            $display("FAIL abort_reach: got %0d beats want 50", beat_d.size());
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.mem_re, bus.mem_addr, bus.out_valid, bus.out_last,
             bus.out_data, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs: got re=%b v=%b l=%b d=%0h busy=%b want all 0",
                     bus.mem_re, bus.out_valid, bus.out_last,
                     bus.out_data, busy);
        end
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        n_cmp++;
        if (saw_done) begin
            n_bad++;
            $display("FAIL abort_nodone: got activity after abort want none");
        end
        fill_mem(1);
        run(1'b0, 1'b1, 0, 1'b0, -1);
        n_cmp++;
        if (timed_out || beat_d.size() != 144 || addrs.size() == 0
            || addrs[0] != 0) begin
            n_bad++;
            $display("FAIL abort_rerun: got %0d beats want 144 from addr 0",
                     beat_d.size());
        end
        for (int i = 0; i < beat_d.size() && i < 144; i++) begin
            n_cmp++;
            if (beat_d[i] !== mem[i]) begin
                n_bad++;
                $display("FAIL abort_beat%0d: got %0h want %0h",
                         i, beat_d[i], mem[i]);
            end
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_small_map();
        test_large_map();
        test_random_ready();
        test_hold();
        test_disturb();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pool_map_streamer.md
POOL_MAP_STREAMER -- requirements
Module: pool_map_streamer

Interface
REQ-001 Parameter ADDR_BIT, default 10, picture memory address width.
REQ-002 Parameter DATA_BIT, default 8, pixel width.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin streaming one pooled map; sampled in IDLE only.
REQ-006 mode  input  1  layer select: 0 = 12x12 map (144 px), 1 = 4x4 map (16 px).
REQ-007 mem_addr  output  ADDR_BIT  picture memory read address.
REQ-008 mem_re  output  1  read strobe; memory returns mem_rdata exactly one cycle later.
REQ-009 mem_rdata  input  DATA_BIT  read data.
REQ-010 out_valid  output  1  output beat available.
REQ-011 out_ready  input  1  downstream accepts beat; transfer when out_valid && out_ready.
REQ-012 out_data  output  DATA_BIT  pixel value.
REQ-013 out_last  output  1  high with the final pixel of the map.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse, run complete.

Function
REQ-016 States IDLE, STREAM, DRAIN, DONE; IDLE->STREAM on start, mode latched at that edge.
REQ-017 Map size dim = latched mode ? 4 : 12; total = dim*dim; mode changes after the start edge have no effect.
REQ-018 Read addresses issued in row-major order 0,1,...,total-1 (addr = x + y*dim); mem_addr = 0 whenever mem_re = 0.
REQ-019 2-entry output FIFO plus in-flight read counter; read issued in STREAM only when (fifo_count + inflight - pop_this_cycle) < 2.
REQ-020 out_valid = FIFO non-empty; out_data/out_last = FIFO head; out_data and out_last held stable while out_valid && !out_ready.
REQ-021 Latency: start at edge T0 -> mem_re with addr 0 in cycle T0+1 -> out_valid in cycle T0+3.
REQ-022 Throughput: with out_ready held high, one beat per cycle, no bubbles after the first beat.
REQ-023 STREAM->DRAIN on the cycle address total-1 is issued; DRAIN->DONE when FIFO empty and inflight = 0.
REQ-024 DONE lasts one cycle with done = 1, then IDLE; done therefore pulses exactly two cycles after the last-beat handshake.
REQ-025 start while busy is ignored; start held high in IDLE after DONE begins a new run.
REQ-026 Simultaneous FIFO push and pop on a full FIFO is not possible under REQ-019; push to a full FIFO never occurs.
REQ-027 Every pixel delivered exactly once, in address order, no loss or duplication under any out_ready pattern.

Reset
REQ-028 rst_n low: state IDLE, FIFO and counters cleared, mem_re/out_valid/out_last/busy/done = 0, mem_addr = 0, out_data = 0.
REQ-029 Reset mid-run aborts the run; returned data in flight is discarded; no done pulse.

Structure
REQ-030 Shared package holds state encoding, map dims 12/4 and pixel counts 144/16, shared with the maxpool scheduler.
REQ-031 One sub-module: stream_fifo2 (2-entry FIFO with count output).

Verification
REQ-032 mode=1, memory[i]=i, out_ready=1: 16 beats of data 0..15, out_last on beat 16 only, done two cycles later, mem_re for exactly 16 cycles.
REQ-033 mode=0, memory[i]=i mod 256, out_ready=1: 144 beats of data in order, first out_valid 3 cycles after start, no gaps.
REQ-034 mode=0, random out_ready (50%): 144 beats in order, data stable while stalled, fifo_count+inflight never > 2.
REQ-035 mode=1, out_ready=0 for 10 cycles after start: exactly 2 reads issued (addr 0,1), then stream resumes to 16 beats when released.
REQ-036 start pulsed during run and mode toggled mid-run: no restart, beat count per latched mode.
REQ-037 rst_n asserted at beat 50 of a mode=0 run: all outputs 0 immediately, no done; new start yields full 144-beat run from address 0.
